// File: rtl/intersection_phase_sched_if.sv
// intersection_phase_sched_if: config, sensor and light/phase status bundle for the scheduler.
// Carries the pedestrian walk signals only when PED_WALK_EN is defined.
interface intersection_phase_sched_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] cfg_green_ns;
  logic [CNT_W-1:0] cfg_green_ew;
  logic [CNT_W-1:0] cfg_yellow;
  logic [CNT_W-1:0] cfg_allred;
  logic             ew_req;
  logic [1:0]       ns_light;
  logic [1:0]       ew_light;
  logic [2:0]       phase;
  logic [CNT_W-1:0] time_left;
  logic             ew_ack;
`ifdef PED_WALK_EN
  logic             ped_req;
  logic [CNT_W-1:0] cfg_walk;
  logic             walk;
  modport master (
    output cfg_green_ns, cfg_green_ew, cfg_yellow, cfg_allred, ew_req, ped_req, cfg_walk,
    input  ns_light, ew_light, phase, time_left, ew_ack, walk
  );
  modport slave (
    input  cfg_green_ns, cfg_green_ew, cfg_yellow, cfg_allred, ew_req, ped_req, cfg_walk,
    output ns_light, ew_light, phase, time_left, ew_ack, walk
  );
`else
  modport master (
    output cfg_green_ns, cfg_green_ew, cfg_yellow, cfg_allred, ew_req,
    input  ns_light, ew_light, phase, time_left, ew_ack
  );
  modport slave (
    input  cfg_green_ns, cfg_green_ew, cfg_yellow, cfg_allred, ew_req,
    output ns_light, ew_light, phase, time_left, ew_ack
  );
`endif
endinterface

// File: rtl/intersection_phase_sched.sv
// intersection_phase_sched: NS/EW phase sequencer with per-phase down-counter and latched side-road request.
// Optional pedestrian walk phase after ALL_RED_2 when PED_WALK_EN is defined.
module intersection_phase_sched #(
  parameter int CNT_W      = 8,
  parameter int ALLRED_RST = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  intersection_phase_sched_if.slave bus
);
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6
  } phase_e;
  localparam logic [1:0] RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] time_left_q, time_left_d, cfg_walk;
  logic             ew_pend_q, ew_pend_d, ew_ack_q, ew_ack_d, ped_go, tz, changing;
`ifdef PED_WALK_EN
  logic             ped_pend_q, ped_pend_d;
  assign ped_go   = ped_pend_q;
  assign cfg_walk = bus.cfg_walk;
  assign bus.walk = phase_q == PED_WALK;
`else
  assign ped_go   = 1'b0;
  assign cfg_walk = '0;
`endif
  assign tz       = time_left_q == '0;
  assign changing = phase_d != phase_q;
  always_comb begin
    phase_d = phase_q;
    if (tz) begin
      unique case (phase_q)
        NS_GREEN:  phase_d = (ew_pend_q || ped_go) ? NS_YELLOW : NS_GREEN;
        NS_YELLOW: phase_d = ALL_RED_1;
        ALL_RED_1: phase_d = EW_GREEN;
        EW_GREEN:  phase_d = EW_YELLOW;
        EW_YELLOW: phase_d = ALL_RED_2;
        ALL_RED_2: phase_d = ped_go ? PED_WALK : NS_GREEN;
        default:   phase_d = NS_GREEN;
      endcase
    end
  end
  // New phase loads its cfg once on entry; otherwise count down and rest at zero.
  always_comb begin
    time_left_d = !changing ? (tz ? '0 : time_left_q - 1'b1)
                : phase_d == NS_GREEN ? bus.cfg_green_ns
                : phase_d == EW_GREEN ? bus.cfg_green_ew
                : (phase_d == NS_YELLOW || phase_d == EW_YELLOW) ? bus.cfg_yellow
                : (phase_d == ALL_RED_1 || phase_d == ALL_RED_2) ? bus.cfg_allred
                : cfg_walk;
    ew_ack_d    = changing && phase_d == EW_GREEN;
    ew_pend_d   = bus.ew_req || (ew_pend_q && !ew_ack_q);
`ifdef PED_WALK_EN
    ped_pend_d  = bus.ped_req || (ped_pend_q && !(changing && phase_d == PED_WALK));
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= ALL_RED_2;
      time_left_q <= CNT_W'(ALLRED_RST);
      ew_pend_q   <= 1'b0;
      ew_ack_q    <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      time_left_q <= time_left_d;
      ew_pend_q   <= ew_pend_d;
      ew_ack_q    <= ew_ack_d;
    end
  end
`ifdef PED_WALK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ped_pend_q <= 1'b0;
    else ped_pend_q <= ped_pend_d;
  end
`endif
  assign bus.ns_light  = phase_q == NS_GREEN ? GREEN : phase_q == NS_YELLOW ? YELLOW : RED;
  assign bus.ew_light  = phase_q == EW_GREEN ? GREEN : phase_q == EW_YELLOW ? YELLOW : RED;
  assign bus.phase     = phase_q;
  assign bus.time_left = time_left_q;
  assign bus.ew_ack    = ew_ack_q;
endmodule

// File: tb/tb_intersection_phase_sched.sv
// tb_intersection_phase_sched: directed checks of phase sequencing, counters, request latching and reset.
module tb_intersection_phase_sched;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  intersection_phase_sched_if #(.CNT_W(8)) bus ();
  intersection_phase_sched #(.CNT_W(8), .ALLRED_RST(3)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset_n) begin
      check("both_not_red", 32'(bus.ns_light != 2'd0 && bus.ew_light != 2'd0), 32'd0);
      check("phase_not_7", 32'(bus.phase == 3'd7), 32'd0);
    end
  end
  task automatic set_cfg(input int gns, input int gew, input int y, input int ar);
    bus.cfg_green_ns = 8'(gns);
    bus.cfg_green_ew = 8'(gew);
    bus.cfg_yellow   = 8'(y);
    bus.cfg_allred   = 8'(ar);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
  int p2 [30] = '{5,5,5,5,0,0,0,0,0,0,1,1,2,2,3,3,3,4,4,5,5,0,0,0,0,0,0,0,0,0};
  int t2 [30] = '{3,2,1,0,5,4,3,2,1,0,1,0,1,0,2,1,0,1,0,1,0,5,4,3,2,1,0,0,0,0};
  initial begin
    int acks, len1, len2;
    bool_found: begin end
    bus.ew_req = 1'b0;
`ifdef PED_WALK_EN
    bus.ped_req  = 1'b0;
    bus.cfg_walk = 8'd7;
`endif
    set_cfg(5, 2, 1, 1);
    // reset state and NS green rest with no request
    do_reset();
    check("rst_ns_light", 32'(bus.ns_light), 32'd0);
    check("rst_ew_light", 32'(bus.ew_light), 32'd0);
    check("rst_ack", 32'(bus.ew_ack), 32'd0);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("rest_phase_c%0d", k), 32'(bus.phase), k < 4 ? 32'd5 : 32'd0);
      check($sformatf("rest_tl_c%0d", k), 32'(bus.time_left), k < 4 ? 32'(3 - k) : k < 10 ? 32'(9 - k) : 32'd0);
      if (k >= 4) check($sformatf("rest_ns_c%0d", k), 32'(bus.ns_light), 32'd1);
      @(negedge clk);
    end
    // one-cycle request pulse during ALL_RED_2 buys exactly one EW round
    do_reset();
    acks = 0;
    for (int k = 0; k < 30; k++) begin
      check($sformatf("pulse_phase_c%0d", k), 32'(bus.phase), 32'(p2[k]));
      check($sformatf("pulse_tl_c%0d", k), 32'(bus.time_left), 32'(t2[k]));
      check($sformatf("pulse_ack_c%0d", k), 32'(bus.ew_ack), 32'(k == 14));
      acks += int'(bus.ew_ack);
      bus.ew_req = (k == 2);
      @(negedge clk);
    end
    check("pulse_ack_count", 32'(acks), 32'd1);
    // all-zero cfg with request held: 1-cycle phases, ack every 6 cycles
    set_cfg(0, 0, 0, 0);
    bus.ew_req = 1'b1;
    do_reset();
    for (int k = 0; k < 28; k++) begin
      if (k >= 4) begin
        check($sformatf("fast_phase_c%0d", k), 32'(bus.phase), 32'((k - 4) % 6));
        check($sformatf("fast_tl_c%0d", k), 32'(bus.time_left), 32'd0);
        check($sformatf("fast_ack_c%0d", k), 32'(bus.ew_ack), 32'((k - 4) % 6 == 3));
      end
      @(negedge clk);
    end
    // mid-phase cfg change affects only the next EW_GREEN
    set_cfg(0, 10, 0, 0);
    do_reset();
    len1 = 0;
    len2 = 0;
    for (int k = 0; k < 28; k++) begin
      if (bus.phase == 3'd3) begin
        if (k < 20) len1++;
        else len2++;
      end
      if (k == 18) check("cfg_ewy1", 32'(bus.phase), 32'd4);
      if (k == 26) check("cfg_ewy2", 32'(bus.phase), 32'd4);
      if (k == 9) bus.cfg_green_ew = 8'd2;
      @(negedge clk);
    end
    check("cfg_ewg_len1", 32'(len1), 32'd11);
    check("cfg_ewg_len2", 32'(len2), 32'd3);
    // async reset in EW_YELLOW with a request pending
    set_cfg(5, 2, 3, 1);
    do_reset();
    for (int k = 0; k < 60 && bus.phase != 3'd4; k++) @(negedge clk);
    check("arst_reached_ewy", 32'(bus.phase), 32'd4);
    #2 reset_n = 1'b0;
    #1;
    check("arst_phase", 32'(bus.phase), 32'd5);
    check("arst_tl", 32'(bus.time_left), 32'd3);
    check("arst_ns", 32'(bus.ns_light), 32'd0);
    check("arst_ew", 32'(bus.ew_light), 32'd0);
    check("arst_ack", 32'(bus.ew_ack), 32'd0);
    @(negedge clk);
    bus.ew_req = 1'b0;
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("arst_drop_phase", 32'(bus.phase), 32'd0);
    check("arst_drop_tl", 32'(bus.time_left), 32'd0);
`ifdef PED_WALK_EN
    set_cfg(5, 2, 1, 1);
    do_reset();
    for (int k = 0; k < 30; k++) begin
      if (k >= 21 && k < 29) begin
        check($sformatf("walk_c%0d", k), 32'(bus.walk), 32'd1);
        check($sformatf("walk_phase_c%0d", k), 32'(bus.phase), 32'd6);
        check($sformatf("walk_lights_c%0d", k), 32'({bus.ns_light, bus.ew_light}), 32'd0);
      end
      if (k == 29) check("walk_to_nsg", 32'(bus.phase), 32'd0);
      bus.ew_req  = (k == 2);
      bus.ped_req = (k == 15);
      @(negedge clk);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
